// File: rtl/async_fifo_rd_drain.sv
// Read-side drain engine for the async_fifo read port (r_clk domain).
// Pops a commanded number of words, forwards them through a 2-entry output
// buffer on a valid/ready stream, and pulses done when the last word leaves.
// Optional feature macro: RD_STATS_EN adds the stall_cnt port and counter.
module async_fifo_rd_drain #(
  parameter int D_SIZE = 8,
  parameter int LEN_W  = 16
) (
  input  logic              r_clk,
  input  logic              rrst,
  input  logic              rd_start,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic [D_SIZE-1:0] rdata,
  input  logic              rempty,
  output logic              rinc,
  output logic [D_SIZE-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef RD_STATS_EN
  ,
  output logic [LEN_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  remain;
  logic [D_SIZE-1:0] mem [2];
  logic              head, tail;
  logic [1:0]        buf_cnt;
  logic              push, pop;

  assign push      = rinc;
  assign out_valid = (buf_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = mem[head];

  // State register.
  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and FSM outputs; DONE is entered on the edge that drains the
  // last buffered word so that done lands in the cycle right after it.
  always_comb begin
    state_nxt = state;
    rinc      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start) state_nxt = (rd_len == '0) ? DONE : READ;
      end
      READ: begin
        busy = 1'b1;
        rinc = !rempty && (remain != '0) && (buf_cnt < 2'd2);
        if ((remain == '0) && ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && pop)))
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remaining word count; loaded only on an accepted start, so rd_len changes
  // during a transfer have no effect.
  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst)                            remain <= '0;
    else if ((state == IDLE) && rd_start) remain <= rd_len;
    else if (rinc)                       remain <= remain - LEN_W'(1);
  end

  // Two-entry output buffer; head/tail ping-pong between the two slots.
  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= rdata;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

`ifdef RD_STATS_EN
  // Saturating count of cycles spent waiting on an empty FIFO mid-transfer.
  always_ff @(posedge r_clk or posedge rrst) begin
    if (rrst)
      stall_cnt <= '0;
    else if ((state == IDLE) && rd_start)
      stall_cnt <= '0;
    else if ((state == READ) && (remain != '0) && rempty && (stall_cnt != '1))
      stall_cnt <= stall_cnt + LEN_W'(1);
  end
`endif

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Self-checking bench for async_fifo_rd_drain: a queue models the FIFO, a
// scoreboard queue holds popped words awaiting delivery downstream.
module tb_async_fifo_rd_drain;

  logic        r_clk;
  logic        rrst;
  logic        rd_start;
  logic [15:0] rd_len;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef RD_STATS_EN
  logic [15:0] stall_cnt;
`endif

  async_fifo_rd_drain #(.D_SIZE(8), .LEN_W(16)) dut (
    .r_clk(r_clk), .rrst(rrst), .rd_start(rd_start), .rd_len(rd_len),
    .rdata(rdata), .rempty(rempty), .rinc(rinc), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
`ifdef RD_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Environment controls
  logic [7:0] fifo_q[$];
  bit hold_empty = 1'b0;
  bit empty_rand = 1'b0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

  // Reference model state
  logic [7:0] exp_q[$];
  bit  active = 1'b0;
  bit  pending_done = 1'b0;
  bit  busy_low_next = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data;
  int  cur_len = 0;
  int  pops = 0;
  int  done_cnt = 0;
  int  stall_model = 0;
  int  cyc = 0;
  int  accept_cyc = 0;
  int  rinc_cyc[$];
  int  hs_cyc[$];

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  task automatic drive_env();
    bit gap;
    gap = empty_rand && ($urandom_range(0, 3) == 0);
    rempty = hold_empty || gap || (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  // FIFO / downstream driver, updated shortly after each rising edge
  initial begin
    drive_env();
    forever begin
      @(posedge r_clk);
      #2;
      drive_env();
    end
  end

  // Monitor and scoreboard, sampled on the falling edge
  initial begin
    bit was_active;
    logic [7:0] w;
    forever begin
      @(negedge r_clk);
      cyc++;
      if (rrst) begin
        exp_q.delete();
        active = 0; pending_done = 0; busy_low_next = 0; prev_stall = 0;
        pops = 0; cur_len = 0; stall_model = 0;
      end else begin
        was_active = active;
        chk(done == pending_done, "done_timing", 32'(done), 32'(pending_done));
        if (busy_low_next) chk(busy == 1'b0, "busy_fall", 32'(busy), 0);
        busy_low_next = 0;
        if (was_active) chk(busy == 1'b1, "busy_high", 32'(busy), 1);
        if (pending_done) begin
          done_cnt++;
          chk(pops == cur_len, "pop_count", 32'(pops), 32'(cur_len));
          chk(exp_q.size() == 0, "buf_empty_at_done", 32'(exp_q.size()), 0);
`ifdef RD_STATS_EN
          chk(stall_cnt == 16'(stall_model), "stall_cnt", 32'(stall_cnt), 32'(stall_model));
`endif
          active = 0;
          busy_low_next = 1;
        end
        pending_done = 0;
        if (!was_active && rd_start) begin
          chk(busy == 1'b0, "idle_at_start", 32'(busy), 0);
          active = 1; cur_len = int'(rd_len); pops = 0; stall_model = 0;
          accept_cyc = cyc; rinc_cyc.delete(); hs_cyc.delete();
          if (rd_len == 16'd0) pending_done = 1;
        end
        if (was_active && (pops < cur_len) && rempty) stall_model++;
        chk(out_valid == (exp_q.size() != 0), "out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (rinc) begin
          chk(was_active && (pops < cur_len) && !rempty && (fifo_q.size() != 0),
              "rinc_legal", 32'(pops), 32'(cur_len));
          if (fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            exp_q.push_back(w);
            pops++;
            rinc_cyc.push_back(cyc);
          end
        end
        if (prev_stall)
          chk(out_valid && (out_data == prev_data), "hold_stable", 32'(out_data), 32'(prev_data));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_word", 32'(out_data), 0);
          end else begin
            w = exp_q.pop_front();
            chk(out_data == w, "out_data", 32'(out_data), 32'(w));
          end
          hs_cyc.push_back(cyc);
          if (active && (cur_len != 0) && (pops == cur_len) && (exp_q.size() == 0))
            pending_done = 1;
        end
      end
    end
  end

  task automatic start_xfer(input int len);
    @(posedge r_clk); #1;
    rd_start = 1'b1;
    rd_len   = 16'(len);
    @(posedge r_clk); #1;
    rd_start = 1'b0;
    rd_len   = 16'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (active && (n < 400)) begin
      @(posedge r_clk);
      n++;
    end
    if (active) chk(1'b0, tag, 32'(n), 400);
    @(posedge r_clk); #1;
  endtask

  initial begin
    int d0;
    rrst = 1'b1; rd_start = 1'b0; rd_len = 16'd0;
    #3;
    chk(out_valid == 0 && rinc == 0 && busy == 0 && done == 0 && out_data == 0,
        "reset_outputs", {out_valid, rinc, busy, done, out_data}, 0);
`ifdef RD_STATS_EN
    chk(stall_cnt == 0, "reset_stall_cnt", 32'(stall_cnt), 0);
`endif
    repeat (2) @(posedge r_clk);
    #1 rrst = 1'b0;

    // Four words back to back
    fifo_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ready_mode = 0;
    d0 = done_cnt;
    start_xfer(4);
    wait_idle("timeout_basic");
    chk(done_cnt - d0 == 1, "basic_done_once", 32'(done_cnt - d0), 1);
    chk(rinc_cyc.size() == 4, "basic_rinc_count", 32'(rinc_cyc.size()), 4);
    if (rinc_cyc.size() == 4) begin
      chk(rinc_cyc[0] == accept_cyc + 1, "first_rinc_latency", 32'(rinc_cyc[0] - accept_cyc), 1);
      chk(rinc_cyc[3] - rinc_cyc[0] == 3, "rinc_back_to_back", 32'(rinc_cyc[3] - rinc_cyc[0]), 3);
    end
    if (hs_cyc.size() != 0 && rinc_cyc.size() != 0)
      chk(hs_cyc[0] == rinc_cyc[0] + 1, "data_latency", 32'(hs_cyc[0] - rinc_cyc[0]), 1);

    // Zero-length command
    fifo_q = '{8'h11, 8'h22};
    d0 = done_cnt;
    start_xfer(0);
    wait_idle("timeout_zero");
    chk(done_cnt - d0 == 1, "zero_done_once", 32'(done_cnt - d0), 1);
    chk(fifo_q.size() == 2, "zero_no_pops", 32'(fifo_q.size()), 2);

    // Downstream stall with excess data in the FIFO
    fifo_q.delete();
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h30 + i));
    ready_mode = 2;
    start_xfer(6);
    repeat (5) @(posedge r_clk);
    #1;
    chk(pops == 2, "stall_two_pops", 32'(pops), 2);
    ready_mode = 0;
    wait_idle("timeout_stall");
    chk(fifo_q.size() == 4, "leftover_words", 32'(fifo_q.size()), 4);
    if (fifo_q.size() != 0) chk(fifo_q[0] == 8'h36, "leftover_head", 32'(fifo_q[0]), 32'h36);

    // Empty FIFO for seven READ cycles
    fifo_q = '{8'h5A, 8'h5B, 8'h5C};
    hold_empty = 1'b1;
    start_xfer(3);
    repeat (7) @(posedge r_clk);
    #1 hold_empty = 1'b0;
    wait_idle("timeout_empty");
    chk(fifo_q.size() == 0, "empty_all_popped", 32'(fifo_q.size()), 0);
`ifdef RD_STATS_EN
    chk(stall_cnt == 16'd7, "stall_cnt_seven", 32'(stall_cnt), 7);
`endif

    // Reset mid-transfer
    fifo_q = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75};
    ready_mode = 2;
    d0 = done_cnt;
    start_xfer(5);
    repeat (4) @(posedge r_clk);
    #1;
    chk(pops == 2, "pre_reset_pops", 32'(pops), 2);
    rrst = 1'b1;
    #1;
    chk(out_valid == 0 && rinc == 0 && busy == 0 && out_data == 0,
        "async_reset", {out_valid, rinc, busy, out_data}, 0);
    @(posedge r_clk); #1 rrst = 1'b0;
    chk(done_cnt == d0, "no_done_after_reset", 32'(done_cnt - d0), 0);
    ready_mode = 0;
    start_xfer(1);
    wait_idle("timeout_post_reset");
    chk(fifo_q.size() == 2 && fifo_q[0] == 8'h74, "post_reset_pop", 32'(fifo_q.size()), 2);

    // Start pulsed again during READ
    fifo_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89, 8'h8A};
    d0 = done_cnt;
    start_xfer(4);
    @(posedge r_clk); #1;
    rd_start = 1'b1; rd_len = 16'd9;
    @(posedge r_clk); #1;
    rd_start = 1'b0;
    wait_idle("timeout_ignore");
    chk(done_cnt - d0 == 1, "ignore_done_once", 32'(done_cnt - d0), 1);
    chk(fifo_q.size() == 6, "ignore_len_kept", 32'(fifo_q.size()), 6);

    // Randomized transfers with FIFO gaps and downstream backpressure
    fifo_q.delete();
    ready_mode = 1;
    empty_rand = 1'b1;
    for (int t = 0; t < 25; t++) begin
      int len;
      len = $urandom_range(0, 8);
      for (int i = 0; i < len + $urandom_range(0, 3); i++)
        fifo_q.push_back(8'($urandom));
      start_xfer(len);
      wait_idle("timeout_random");
    end
    empty_rand = 1'b0;
    ready_mode = 0;

    repeat (3) @(posedge r_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_drain.md
# async_fifo_rd_drain

Read-side drain engine for the `async_fifo` read port, in the `r_clk` domain. On a start command it pops exactly `rd_len` words from the FIFO, driving `rinc` only while the FIFO is non-empty and local buffering has room. It forwards each word to a downstream consumer over a valid/ready stream through a 2-entry output buffer, and reports completion. It is the consumer counterpart of the FIFO write-side producer.

## Interface
Parameters:
- `D_SIZE`, default 8: FIFO data width.
- `LEN_W`, default 16: width of the transfer-length field.

Ports:
- `r_clk`  in  1: read-domain clock; all logic is on its rising edge.
- `rrst`  in  1: asynchronous, active-high reset. Assertion clears all state immediately; deassertion is synchronous to `r_clk` upstream.
- `rd_start`  in  1: single-cycle command to begin a transfer; sampled only in IDLE.
- `rd_len`  in  LEN_W: word count, sampled with `rd_start`.
- `rdata`  in  D_SIZE: FIFO read data. Show-ahead: the word at the read pointer is valid whenever `rempty`=0.
- `rempty`  in  1: FIFO empty flag.
- `rinc`  out  1: FIFO pop strobe (combinational).
- `out_data`  out  D_SIZE: downstream data (head of the buffer).
- `out_valid`  out  1: downstream valid.
- `out_ready`  in  1: downstream ready.
- `busy`  out  1: high in READ and DONE.
- `done`  out  1: one-cycle completion pulse.
- `stall_cnt`  out  LEN_W: exists only with `RD_STATS_EN`.

## Operation
- States: IDLE, READ, DONE.
  - IDLE → READ on `rd_start`=1 with `rd_len`≠0. Load `remain`=`rd_len`.
  - IDLE → DONE on `rd_start`=1 with `rd_len`=0. No pops occur.
  - READ → DONE when `remain`=0 and the buffer is empty, i.e. the last word has been accepted downstream.
  - DONE → IDLE unconditionally after 1 cycle. `done`=1 only in the DONE cycle.
- `rinc` = (state==READ) & !`rempty` & (`remain`≠0) & (`buf_cnt`<2).
  - On each `rinc` edge: `rdata` is written into the buffer and `remain` decrements.
- Buffer: 2-entry FIFO with `buf_cnt` range 0..2.
  - `out_valid` = (`buf_cnt`≠0). `out_data` = head entry.
  - A handshake is `out_valid`&`out_ready`. It pops the head.
  - A simultaneous push and pop leaves `buf_cnt` unchanged. Order is preserved.
- `rd_start` in READ or DONE is ignored. A new `rd_len` cannot corrupt an active transfer.
- `out_data` holds stable while `out_valid`=1 and `out_ready`=0.
- `remain` never underflows. `rinc` is gated when `remain`=0, even if the FIFO holds more data; the extra words stay in the FIFO.
- `rempty` toggling mid-transfer only pauses pops. There is no timeout.

## Timing
- Reset values: state=IDLE, `remain`=0, `buf_cnt`=0, `rinc`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `stall_cnt`=0.
- Start latency: `rd_start` at edge k puts state in READ after k. The first `rinc` can be high in cycle k+1, if the FIFO is non-empty.
- Data latency: a word popped at edge p is on `out_data` with `out_valid`=1 after edge p (1 cycle).
- Throughput: 1 word/cycle sustained while `rempty`=0 and `out_ready`=1.
- With `out_ready`=0, at most 2 pops occur, then `rinc` stays low until a handshake frees a slot.
- `done` is asserted the cycle after the edge that accepts the final word downstream. `busy` falls one cycle later.
- `rrst` asserted mid-transfer: outputs return to reset values immediately. Buffered words are discarded and no `done` is issued.

## Configuration
- `RD_STATS_EN` defined:
  - adds the `stall_cnt` port;
  - counts cycles in READ with `remain`≠0 and `rempty`=1;
  - saturates at all-ones;
  - clears on `rd_start` accepted in IDLE and on `rrst`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then `rd_start` with `rd_len`=4. FIFO holds A1,B2,C3,D4 and `out_ready`=1 → four consecutive `rinc` pulses; `out_data` sequence A1,B2,C3,D4 one cycle after each pop; `done` pulses once; `busy` falls one cycle after `done`.
- `rd_len`=0 → no `rinc`; `done` pulse in the cycle after `rd_start`.
- `rd_len`=6, FIFO has 10 words, `out_ready`=0 for 5 cycles then 1 → exactly 2 pops during the stall, 6 pops total, 4 words left in the FIFO, output order matches the FIFO order.
- `rd_len`=3 with `rempty`=1 for 7 cycles, then 3 words arrive → no `rinc` while empty; completion follows. With `RD_STATS_EN`, `stall_cnt`=7.
- Assert `rrst` after 2 of 5 words are popped → `out_valid`, `rinc`, `busy` go to 0 immediately; a later `rd_start` with `rd_len`=1 pops the next FIFO word normally.
- `rd_start` pulsed again during READ with `rd_len`=9 → ignored; the original count completes and exactly one `done` pulse occurs.
